// File: rtl/regfile_scoreboard.sv
// Register file with write-to-read bypass and a per-register pending-write scoreboard.
// The storage array is unreset; a clear sequencer zeroes it one entry per cycle.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_ena,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_ena,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DEPTH-1:0]    pending_q, pending_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_drop;

    assign wr_drop = (ZERO_REG != 0) && (wr_addr == '0);
    assign ready   = (state_q == RUN);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
                pending_d = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                // A write in the clr_req cycle still lands; the sweep overwrites it.
                mem_we = wr_ena && !wr_drop;
                if (clr_req) begin
                    state_d   = CLEAR;
                    idx_d     = '0;
                    pending_d = '0;
                end else begin
                    for (int r = 0; r < DEPTH; r++) begin
                        pending_d[r] = (claim_ena && (claim_addr == ADDR_W'(r))) ||
                                       (pending_q[r] && !(wr_ena && (wr_addr == ADDR_W'(r))));
                    end
                    if (ZERO_REG != 0) begin
                        pending_d[0] = 1'b0;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              wr_hit;
        logic              claim_hit;
        logic              zero_hit;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr      = rd_addr[gi*ADDR_W +: ADDR_W];
        assign wr_hit    = (BYPASS != 0) && wr_ena && (wr_addr == addr);
        assign claim_hit = claim_ena && (claim_addr == addr);
        assign zero_hit  = (ZERO_REG != 0) && (addr == '0);

        // A forwarded write retires the pending bit unless a new claim re-arms it.
        always_comb begin
            data = '0;
            busy = 1'b0;
            if ((state_q == RUN) && !zero_hit) begin
                if (wr_hit) begin
                    data = wr_data;
                    busy = pending_q[addr] && claim_hit;
                end else begin
                    data = mem_q[addr];
                    busy = pending_q[addr];
                end
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data;
        assign rd_busy[gi]                  = busy;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised next-generation register file for the multicycle/pipelined RISC-V core: configurable data width, depth and number of read ports.
- Adds a write-to-read bypass and a per-register pending-write scoreboard, so issue logic can detect RAW hazards.
- The storage array has no reset. Instead, a clear sequencer zeroes one entry per cycle after reset or on request.
- Sits between decode/issue (reads, claims) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- N_RD, 2, number of independent read ports
- ZERO_REG, 1, when 1 entry 0 always reads 0, ignores writes and claims, and is never pending
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_ena  in  1  writeback write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_ena  in  1  issue marks a destination register as pending
- claim_addr  in  ADDR_W  register being claimed
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed read data, combinational
- rd_busy  out  N_RD  1 = the addressed register has an outstanding claim
- clr_req  in  1  request a full clear sweep (single-cycle pulse is sufficient)
- ready  out  1  1 = sweep done, array usable

Behaviour:
- FSM states: CLEAR and RUN. While rst is high: state = CLEAR, sweep index = 0, all pending bits = 0, ready = 0.
- CLEAR state:
  - Each cycle, entry[idx] <= 0 and idx increments.
  - When idx == DEPTH-1 the last entry is written and the state moves to RUN. ready rises the following cycle.
  - Sweep takes exactly DEPTH cycles after rst deasserts.
  - While in CLEAR: wr_ena, claim_ena and clr_req are ignored, rd_data forced to 0, rd_busy forced to 0.
- RUN state: ready = 1.
  - Write: on wr_ena, entry[wr_addr] <= wr_data at the edge. If ZERO_REG and wr_addr == 0, the write is dropped.
  - Read port i (combinational):
    - ZERO_REG and addr == 0 -> 0.
    - Otherwise, if BYPASS and wr_ena and wr_addr == rd_addr_i -> wr_data.
    - Otherwise -> entry[rd_addr_i].
  - Scoreboard, per register r:
    - Next pending = (claim_ena && claim_addr == r) OR (pending[r] AND NOT (wr_ena && wr_addr == r)).
    - A claim and a write to the same register in the same cycle leave it pending (the new producer wins).
    - With ZERO_REG, register 0 is never set.
  - rd_busy_i = pending[rd_addr_i]. If BYPASS and a write to that address is happening this cycle, rd_busy_i = 0 unless pending would be re-set by a simultaneous claim. With BYPASS = 0, rd_busy_i reflects the registered pending bit only.
  - clr_req in RUN: at the next edge, state -> CLEAR, idx = 0, all pending bits cleared, ready falls. Any write in that same cycle is still committed, then overwritten by the sweep.
- Reset mid-sweep or mid-operation: asynchronous return to CLEAR with idx = 0; the sweep restarts from the beginning.
- Multiple read ports may address the same register; all return identical data.
- No write-write conflicts are possible, since there is a single write port.

Test Plan:
- Reset, then rst deasserts: ready = 0 for exactly 32 cycles, then 1. Reading any of x0..x31 returns 0 and rd_busy = 0.
- After ready: write 0xDEADBEEF to x5. Next cycle rd_addr0 = 5 returns 0xDEADBEEF. A write of 0x1234 to x0 still reads 0 on x0.
- BYPASS: in the same cycle, wr_ena to x7 with 0xA5A5A5A5 and rd_addr1 = 7. rd_data1 = 0xA5A5A5A5 in that cycle. With BYPASS = 0 it returns the old value.
- Scoreboard:
  - Claim x10: the next cycle rd_busy = 1 for x10.
  - Write x10 = 0x42: busy = 0 in the write cycle (bypass) and after.
  - Claim and write x10 in the same cycle: x10 is still busy.
  - Claim x0: never busy.
- clr_req after writing x3 = 0x55: ready = 0 for 32 cycles, then x3 reads 0 and all busy bits are 0. Writes issued during CLEAR are not stored.
- rst asserted at sweep index 17, held 2 cycles, then released: ready = 0 for 32 more cycles; all entries 0.
- Parameter sweep DATA_W=16, ADDR_W=3, N_RD=3, ZERO_REG=0: sweep lasts 8 cycles; x0 writable (0xBEEF read back on all 3 ports).
